turret_bullet_ctrl: RTL and testbench

- Consumes one turret's aim outputs: per-frame bullet motion (x/y) and muzzle position (x/y).
- On a fire key press, launches a single bullet and latches the aim at that instant.
- Steps the bullet once per frame tick until it leaves the screen or is reported hit, then enforces a cooldown before the next shot.
- Sits between the turret aim FSM and the sprite/collision logic; one instance per turret.

---
 rtl/game_pkg.sv | 19 +
 rtl/key_edge_detect.sv | 25 ++
 rtl/turret_bullet_ctrl.sv | 115 +++++++++++
 tb/tb_turret_bullet_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the turret/bullet game blocks.
package game_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } bullet_state_t;

    localparam coord_t SCREEN_X_MAX = 10'd639;
    localparam coord_t SCREEN_Y_MAX = 10'd479;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_DOWN  = 8'h51;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for one keycode; fires once per press, re-arms on release.
module key_edge_detect
    import game_pkg::*;
#(
    parameter logic [7:0] FIRE_KEY = KEY_SPACE
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       fire_edge
);

    logic key_hit;
    logic key_prev;

    assign key_hit = (keycode == FIRE_KEY);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) key_prev <= 1'b0;
        else        key_prev <= key_hit;
    end

    assign fire_edge = key_hit && !key_prev;

endmodule

// File: rtl/turret_bullet_ctrl.sv
// Single-bullet launcher for one turret: launch on fire edge, step per frame,
// end on hit or off-screen, then cool down before the next shot.
module turret_bullet_ctrl
    import game_pkg::*;
#(
    parameter logic [7:0] FIRE_KEY        = KEY_SPACE,
    parameter coord_t     X_MAX           = SCREEN_X_MAX,
    parameter coord_t     Y_MAX           = SCREEN_Y_MAX,
    parameter int         COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  coord_t     aim_motion_x,
    input  coord_t     aim_motion_y,
    input  coord_t     aim_pos_x,
    input  coord_t     aim_pos_y,
    input  logic       hit,
    output logic       bullet_active,
    output coord_t     bullet_x,
    output coord_t     bullet_y,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       ready,
    output logic [7:0] shots_fired
);

    localparam logic [7:0] CD_INIT = 8'(COOLDOWN_FRAMES);

    bullet_state_t state, state_nxt;
    coord_t        mot_x, mot_y;
    logic [7:0]    cd_cnt;
    logic          fire_edge;
    logic          launch, step, end_hit, end_miss, off_screen;

    key_edge_detect #(.FIRE_KEY(FIRE_KEY)) u_key (
        .Clk       (Clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .fire_edge (fire_edge)
    );

    // Unsigned compare: a coordinate stepped below zero wraps high and counts as off-screen.
    assign off_screen = (bullet_x > X_MAX) || (bullet_y > Y_MAX);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        step      = 1'b0;
        end_hit   = 1'b0;
        end_miss  = 1'b0;
        case (state)
            IDLE: if (fire_edge) begin
                launch    = 1'b1;
                state_nxt = FLY;
            end
            FLY: begin
                if (hit) begin
                    end_hit   = 1'b1;
                    state_nxt = COOL;
                end else if (off_screen) begin
                    end_miss  = 1'b1;
                    state_nxt = COOL;
                end else if (frame_tick) begin
                    step = 1'b1;
                end
            end
            COOL: if (frame_tick && cd_cnt <= 8'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bullet_active <= 1'b0;
            bullet_x      <= '0;
            bullet_y      <= '0;
            mot_x         <= '0;
            mot_y         <= '0;
            cd_cnt        <= '0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
            shots_fired   <= '0;
        end else begin
            bullet_active <= (state_nxt == FLY);
            hit_pulse     <= end_hit;
            miss_pulse    <= end_miss;
            if (launch) begin
                bullet_x <= aim_pos_x;
                bullet_y <= aim_pos_y;
                mot_x    <= aim_motion_x;
                mot_y    <= aim_motion_y;
                if (shots_fired != 8'hFF) shots_fired <= shots_fired + 8'd1;
            end else if (step) begin
                bullet_x <= bullet_x + mot_x;
                bullet_y <= bullet_y + mot_y;
            end
            if (end_hit || end_miss)
                cd_cnt <= CD_INIT;
            else if (state == COOL && frame_tick && cd_cnt != 8'd0)
                cd_cnt <= cd_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_turret_bullet_ctrl.sv
// Directed bench for turret_bullet_ctrl with hand-computed expectations.
module tb_turret_bullet_ctrl;
    import game_pkg::*;

    logic       Clk, Reset, frame_tick, hit;
    logic [7:0] keycode;
    coord_t     aim_motion_x, aim_motion_y, aim_pos_x, aim_pos_y;
    logic       bullet_active, hit_pulse, miss_pulse, ready;
    coord_t     bullet_x, bullet_y;
    logic [7:0] shots_fired;

    int tests = 0;
    int fails = 0;

    turret_bullet_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .keycode      (keycode),
        .aim_motion_x (aim_motion_x),
        .aim_motion_y (aim_motion_y),
        .aim_pos_x    (aim_pos_x),
        .aim_pos_y    (aim_pos_y),
        .hit          (hit),
        .bullet_active(bullet_active),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .ready        (ready),
        .shots_fired  (shots_fired)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_aim(input coord_t px, input coord_t py, input coord_t mx, input coord_t my);
        aim_pos_x = px; aim_pos_y = py; aim_motion_x = mx; aim_motion_y = my;
    endtask

    task automatic fire();
        keycode = 8'h2C;
        step();
        keycode = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        frame_tick = 1'b1;
        while (!ready && n < 40) begin
            step();
            n++;
        end
        frame_tick = 1'b0;
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_wait_idle: ready=%b want 1 after %0d cycles", name, ready, n);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; frame_tick = 0; hit = 0; keycode = 0;
        set_aim(0, 0, 0, 0);
        step(); step();
        tests++;
        if ({bullet_active, hit_pulse, miss_pulse, bullet_x, bullet_y, shots_fired} !== 31'd0) begin
            fails++;
            $display("FAIL reset_outputs: act=%b hp=%b mp=%b x=%0d y=%0d shots=%0d want all 0",
                     bullet_active, hit_pulse, miss_pulse, bullet_x, bullet_y, shots_fired);
        end
        Reset = 1'b1;
        step();
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
        hit = 1'b1;
        step();
        hit = 1'b0;
        tests++;
        if (hit_pulse !== 1'b0 || bullet_active !== 1'b0) begin
            fails++; $display("FAIL idle_hit_ignored: hp=%b act=%b want 0 0", hit_pulse, bullet_active);
        end
    endtask

    task automatic test_launch_step();
        set_aim(10'd510, 10'd420, 10'h3FE, 10'd0);
        frame_tick = 1'b1;
        fire();
        frame_tick = 1'b0;
        tests++;
        if (bullet_active !== 1'b1 || bullet_x !== 10'd510 || bullet_y !== 10'd420 || shots_fired !== 8'd1) begin
            fails++;
            $display("FAIL launch: act=%b x=%0d y=%0d shots=%0d want 1 510 420 1",
                     bullet_active, bullet_x, bullet_y, shots_fired);
        end
        frame_tick = 1'b1;
        repeat (3) step();
        frame_tick = 1'b0;
        tests++;
        if (bullet_x !== 10'd504 || bullet_y !== 10'd420) begin
            fails++; $display("FAIL step3: x=%0d y=%0d want 504 420", bullet_x, bullet_y);
        end
        hit = 1'b1;
        step();
        hit = 1'b0;
        tests++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || bullet_active !== 1'b0 || bullet_x !== 10'd504) begin
            fails++;
            $display("FAIL hit_end: hp=%b mp=%b act=%b x=%0d want 1 0 0 504",
                     hit_pulse, miss_pulse, bullet_active, bullet_x);
        end
        step();
        tests++;
        if (hit_pulse !== 1'b0) begin fails++; $display("FAIL hit_pulse_width: got %b want 0", hit_pulse); end
        wait_idle("launch");
    endtask

    task automatic test_miss_cooldown();
        set_aim(10'd558, 10'd422, 10'd0, 10'h3FE);
        fire();
        frame_tick = 1'b1;
        repeat (212) step();
        tests++;
        if (bullet_y !== 10'd1022 || bullet_active !== 1'b1 || miss_pulse !== 1'b0) begin
            fails++;
            $display("FAIL pre_miss: y=%0d act=%b mp=%b want 1022 1 0", bullet_y, bullet_active, miss_pulse);
        end
        step();
        tests++;
        if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || bullet_active !== 1'b0 ||
            bullet_x !== 10'd558 || bullet_y !== 10'd1022) begin
            fails++;
            $display("FAIL miss_end: mp=%b hp=%b act=%b x=%0d y=%0d want 1 0 0 558 1022",
                     miss_pulse, hit_pulse, bullet_active, bullet_x, bullet_y);
        end
        repeat (7) step();
        tests++;
        if (ready !== 1'b0 || miss_pulse !== 1'b0) begin
            fails++; $display("FAIL cool_7: ready=%b mp=%b want 0 0", ready, miss_pulse);
        end
        step();
        frame_tick = 1'b0;
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL cool_8: ready=%b want 1", ready); end
    endtask

    task automatic test_hit_priority();
        set_aim(10'd700, 10'd100, 10'd0, 10'd0);
        fire();
        tests++;
        if (bullet_active !== 1'b1 || shots_fired !== 8'd3) begin
            fails++; $display("FAIL prio_launch: act=%b shots=%0d want 1 3", bullet_active, shots_fired);
        end
        hit = 1'b1;
        step();
        hit = 1'b0;
        tests++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || bullet_active !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL hit_prio: hp=%b mp=%b act=%b ready=%b want 1 0 0 0",
                     hit_pulse, miss_pulse, bullet_active, ready);
        end
        wait_idle("prio");
    endtask

    task automatic test_held_key();
        set_aim(10'd700, 10'd100, 10'd0, 10'd0);
        keycode = 8'h2C;
        frame_tick = 1'b1;
        repeat (20) step();
        frame_tick = 1'b0;
        tests++;
        if (shots_fired !== 8'd4 || bullet_active !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL held_key: shots=%0d act=%b ready=%b want 4 0 1", shots_fired, bullet_active, ready);
        end
        keycode = 8'h00;
        step();
        fire();
        tests++;
        if (shots_fired !== 8'd5 || bullet_active !== 1'b1) begin
            fails++; $display("FAIL rearm: shots=%0d act=%b want 5 1", shots_fired, bullet_active);
        end
        wait_idle("held");
    endtask

    task automatic test_ignore_in_flight();
        set_aim(10'd100, 10'd100, 10'd1, 10'd1);
        fire();
        set_aim(10'd300, 10'd300, 10'd5, 10'd5);
        frame_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            keycode = (i % 2 == 1) ? 8'h2C : 8'h00;
            step();
        end
        frame_tick = 1'b0;
        keycode = 8'h00;
        tests++;
        if (bullet_x !== 10'd104 || bullet_y !== 10'd104 || shots_fired !== 8'd6) begin
            fails++;
            $display("FAIL fly_ignore: x=%0d y=%0d shots=%0d want 104 104 6", bullet_x, bullet_y, shots_fired);
        end
        hit = 1'b1;
        step();
        hit = 1'b0;
        step();
        keycode = 8'h2C;
        step();
        keycode = 8'h00;
        step();
        wait_idle("ignore");
        step();
        tests++;
        if (bullet_active !== 1'b0 || shots_fired !== 8'd6) begin
            fails++; $display("FAIL cool_fire_dropped: act=%b shots=%0d want 0 6", bullet_active, shots_fired);
        end
    endtask

    task automatic test_saturate();
        set_aim(10'd700, 10'd0, 10'd0, 10'd0);
        for (int i = 0; i < 249; i++) begin
            fire();
            wait_idle("sat");
        end
        tests++;
        if (shots_fired !== 8'd255) begin fails++; $display("FAIL sat_reach: shots=%0d want 255", shots_fired); end
        for (int i = 0; i < 11; i++) begin
            fire();
            wait_idle("sat2");
        end
        tests++;
        if (shots_fired !== 8'd255) begin fails++; $display("FAIL sat_hold: shots=%0d want 255", shots_fired); end
    endtask

    task automatic test_reset_midflight();
        set_aim(10'd200, 10'd200, 10'd0, 10'd0);
        fire();
        tests++;
        if (bullet_active !== 1'b1) begin fails++; $display("FAIL rst_pre: act=%b want 1", bullet_active); end
        #2;
        Reset = 1'b0;
        #1;
        tests++;
        if (bullet_active !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 ||
            shots_fired !== 8'd0 || bullet_x !== 10'd0) begin
            fails++;
            $display("FAIL rst_mid: act=%b hp=%b mp=%b shots=%0d x=%0d want 0 0 0 0 0",
                     bullet_active, hit_pulse, miss_pulse, shots_fired, bullet_x);
        end
        #10;
        Reset = 1'b1;
        step();
        tests++;
        if (ready !== 1'b1 || bullet_active !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            fails++;
            $display("FAIL rst_after: ready=%b act=%b hp=%b mp=%b want 1 0 0 0",
                     ready, bullet_active, hit_pulse, miss_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_launch_step();
        test_miss_cooldown();
        test_hit_priority();
        test_held_key();
        test_ignore_in_flight();
        test_saturate();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
